ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//   Instruction-fetch front end: consumer side of the next-PC interface. Holds the
//   architectural PC, fetches the word at PC from instruction memory over a req/gnt +
//   rvalid handshake, presents {pc, inst} to decode and, on retire, loads the next-PC
//   value. Detects misaligned targets and fetch timeouts.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on reset
//   TIMEOUT      16             max cycles in WAIT before a bus-timeout error (>=1)
//   TW           5              width of timeout counter; 2**TW > TIMEOUT
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   synchronous reset, active-high
//   npc_i        in   32  next PC from next-PC logic
//   retire_i     in   1   current instruction done; take npc_i
//   imem_req     out  1   fetch request valid
//   imem_addr    out  32  fetch address (= pc_o)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid
//   imem_rdata   in   32  read data
//   pc_o         out  32  PC of instruction in flight/held
//   inst_o       out  32  latched instruction
//   inst_valid   out  1   inst_o valid for pc_o
//   fetch_err    out  1   sticky error flag
//   err_code     out  2   00 none, 01 misaligned npc, 10 fetch timeout
//   fetch_cnt    out  32  completed fetches, wraps 32'hFFFF_FFFF -> 0
// BEHAVIOUR
//   Reset (sync, rst=1 at edge): pc_o=RESET_PC, inst_o=0, inst_valid=0, fetch_err=0,
//     err_code=00, fetch_cnt=0, timer=0, state=REQ. Reset wins over every other input.
//   States: REQ, WAIT, VALID, ERR (2-bit encoding).
//   REQ:   imem_req=1, imem_addr=pc_o. gnt=1 -> WAIT, timer=0. rvalid ignored.
//   WAIT:  imem_req=0. rvalid=1 -> inst_o<=imem_rdata, inst_valid<=1, fetch_cnt+=1,
//          -> VALID. Else timer+=1; timer==TIMEOUT-1 without rvalid -> ERR, code 10.
//          rvalid in the same cycle as the timeout edge: data accepted, no error.
//   VALID: inst_valid=1 held, inst_o/pc_o stable until retire_i.
//          retire_i & npc_i[1:0]==0 -> pc_o<=npc_i, inst_valid<=0, -> REQ.
//          retire_i & npc_i[1:0]!=0 -> pc_o unchanged, inst_valid<=0, -> ERR, code 01.
//   ERR:   imem_req=0, inst_valid=0, fetch_err=1; stays until rst.
//   retire_i outside VALID: ignored. gnt outside REQ: ignored.
//   Latency: REQ accepted with gnt at cycle t, rvalid at t+k -> inst_valid at t+k+1;
//     retire at cycle r -> imem_req for npc at r+1. Zero-wait memory: 3 cycles/inst.
//   Outputs imem_req/imem_addr decoded from state/pc registers (Moore, no in->out path).
//   Reset mid-WAIT: outstanding response is dropped; imem shares rst, no stale rvalid.
// STRUCTURE
//   ifu_defs.v (`include): state codes IFU_REQ/IFU_WAIT/IFU_VALID/IFU_ERR,
//     error codes ERR_NONE/ERR_MISALIGN/ERR_TIMEOUT.
//   Sub-module fetch_timer: TW-bit counter, inputs clr/en, output expired (==TIMEOUT-1).
//   Top holds FSM, PC/inst registers, fetch_cnt.
// TESTING
//   1 Reset, gnt=1 at once, rvalid next cycle rdata=32'h0000_0013 -> inst_valid=1,
//     pc_o=0, fetch_cnt=1; retire with npc=4 -> imem_addr=4 next cycle.
//   2 gnt held low 5 cycles in REQ -> imem_req stays 1, addr stable, no state change.
//   3 rvalid after 15 WAIT cycles (TIMEOUT=16) -> accepted; after 16 -> ERR,
//     err_code=10, imem_req=0 until rst.
//   4 retire with npc=32'h0000_0102 -> ERR, code 01, pc_o unchanged, inst_valid=0.
//   5 rst asserted in WAIT with rvalid same cycle -> pc_o=RESET_PC, inst_valid=0, REQ.
//   6 retire_i pulsed in REQ/WAIT -> ignored; preload fetch_cnt near wrap via
//     force, fetch once -> wraps to 0.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared FSM state and error code encodings for the fetch front end
package ifu_fetch_pkg;
  typedef enum logic [1:0] {
    IFU_REQ   = 2'b00,
    IFU_WAIT  = 2'b01,
    IFU_VALID = 2'b10,
    IFU_ERR   = 2'b11
  } state_t;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_t;
endpackage

// File: rtl/ifu_fetch_timer.sv
// ifu_fetch_timer: counts cycles spent waiting for a fetch response
module ifu_fetch_timer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC holder and req/gnt/rvalid instruction fetch FSM with error detection
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          TW       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  input  logic        retire_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output logic [31:0] fetch_cnt
);
  state_t state, state_n;
  logic   expired;
  logic   misaligned;
  assign misaligned = npc_i[1:0] != 2'b00;
  ifu_fetch_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != IFU_WAIT),
    .en      (state == IFU_WAIT && !imem_rvalid),
    .expired (expired)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IFU_REQ:   state_n = imem_gnt ? IFU_WAIT : IFU_REQ;
      IFU_WAIT:  state_n = imem_rvalid ? IFU_VALID : expired ? IFU_ERR : IFU_WAIT;
      IFU_VALID: state_n = !retire_i ? IFU_VALID : misaligned ? IFU_ERR : IFU_REQ;
      default:   state_n = IFU_ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IFU_REQ;
      pc_o       <= RESET_PC;
      inst_o     <= '0;
      inst_valid <= 1'b0;
      err_code   <= ERR_NONE;
      fetch_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state == IFU_WAIT && imem_rvalid) begin
        inst_o     <= imem_rdata;
        inst_valid <= 1'b1;
        fetch_cnt  <= fetch_cnt + 1'b1;
      end
      if (state == IFU_WAIT && !imem_rvalid && expired) err_code <= ERR_TIMEOUT;
      if (state == IFU_VALID && retire_i) begin
        inst_valid <= 1'b0;
        if (misaligned) err_code <= ERR_MISALIGN;
        else pc_o <= npc_i;
      end
    end
  end
  // ERR is absorbing until reset, so the state itself is the sticky flag
  assign fetch_err = state == IFU_ERR;
  assign imem_req  = state == IFU_REQ;
  assign imem_addr = pc_o;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: vector table, directed corner sequences and randomized fetch traffic vs a PC model
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_i;
  logic        retire_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic [31:0] fetch_cnt;

  ifu_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .npc_i       (npc_i),
    .retire_i    (retire_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .inst_valid  (inst_valid),
    .fetch_err   (fetch_err),
    .err_code    (err_code),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  typedef struct {
    int          gdel;
    int          w;
    logic [31:0] data;
    logic [31:0] npc;
    logic [1:0]  code;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    retire_i = 1'($urandom_range(0, 1));
    npc_i    = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; npc_i = '0; retire_i = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step();
    step();
    rst = 1'b0;
    exp_pc  = RESET_PC;
    exp_cnt = '0;
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
  endtask

  // gdel cycles of withheld grant, then w WAIT cycles with no response
  task automatic fetch(input int gdel, input int w, input logic [31:0] data);
    chk("req", 32'(imem_req), 32'h1);
    chk("addr", imem_addr, exp_pc);
    for (int i = 0; i < gdel; i++) begin
      noise();
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_gnt = 1'b0;
      step();
      chk("req_hold", 32'(imem_req), 32'h1);
      chk("addr_hold", imem_addr, exp_pc);
    end
    noise();
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < w; i++) begin
      noise();
      imem_gnt = 1'($urandom_range(0, 1));
      step();
    end
    imem_gnt = 1'b0;
    if (w < TIMEOUT) begin
      noise();
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      step();
      imem_rvalid = 1'b0;
      retire_i    = 1'b0;
      exp_cnt++;
      chk("valid", 32'(inst_valid), 32'h1);
      chk("inst", inst_o, data);
      chk("pc", pc_o, exp_pc);
      chk("cnt", fetch_cnt, exp_cnt);
      chk("valid_req", 32'(imem_req), 32'h0);
      chk("valid_err", 32'(fetch_err), 32'h0);
    end else begin
      retire_i = 1'b0;
      chk("to_err", 32'(fetch_err), 32'h1);
      chk("to_code", 32'(err_code), 32'h2);
      chk("to_req", 32'(imem_req), 32'h0);
      chk("to_valid", 32'(inst_valid), 32'h0);
    end
  endtask

  task automatic retire(input logic [31:0] npc);
    retire_i = 1'b1;
    npc_i    = npc;
    step();
    retire_i = 1'b0;
    chk("ret_valid", 32'(inst_valid), 32'h0);
    if (npc[1:0] == 2'b00) begin
      exp_pc = npc;
      chk("ret_req", 32'(imem_req), 32'h1);
      chk("ret_addr", imem_addr, npc);
    end else begin
      chk("mis_err", 32'(fetch_err), 32'h1);
      chk("mis_code", 32'(err_code), 32'h1);
      chk("mis_pc", pc_o, exp_pc);
      chk("mis_req", 32'(imem_req), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0013, 32'h0000_0004, 2'b00};
    vecs[1] = '{5, 3, 32'hDEAD_BEEF, 32'h0000_0100, 2'b00};
    vecs[2] = '{1, 15, 32'h1234_5678, 32'h0000_0008, 2'b00};
    vecs[3] = '{0, 16, 32'h0, 32'h0, 2'b10};
    vecs[4] = '{2, 4, 32'hCAFE_0001, 32'h0000_0102, 2'b01};
    vecs[5] = '{0, 1, 32'h0BAD_F00D, 32'h0000_0007, 2'b01};
    vecs[6] = '{3, 14, 32'h0000_0033, 32'hFFFF_FFFC, 2'b00};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      fetch(vecs[v].gdel, vecs[v].w, vecs[v].data);
      if (vecs[v].w < TIMEOUT) retire(vecs[v].npc);
      chk("vec_code", 32'(err_code), 32'(vecs[v].code));
      if (vecs[v].code != 2'b00)
        for (int i = 0; i < 3; i++) begin
          imem_gnt = 1'b1; imem_rvalid = 1'b1; retire_i = 1'b1; npc_i = 32'h40;
          step();
          chk("err_sticky_req", 32'(imem_req), 32'h0);
          chk("err_sticky_flag", 32'(fetch_err), 32'h1);
          chk("err_sticky_code", 32'(err_code), 32'(vecs[v].code));
          chk("err_sticky_valid", 32'(inst_valid), 32'h0);
        end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; retire_i = 1'b0;
    end

    // reset arriving in WAIT together with a response drops the response
    do_reset();
    retire(32'h0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_0000;
    step();
    rst = 1'b0; imem_rvalid = 1'b0;
    chk("rstw_pc", pc_o, RESET_PC);
    chk("rstw_valid", 32'(inst_valid), 32'h0);
    chk("rstw_cnt", fetch_cnt, 32'h0);
    chk("rstw_req", 32'(imem_req), 32'h1);

    // retire outside VALID is ignored
    do_reset();
    retire_i = 1'b1; npc_i = 32'h0000_0040;
    step();
    chk("ign_req_addr", imem_addr, RESET_PC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    step();
    retire_i = 1'b0;
    chk("ign_wait_pc", pc_o, RESET_PC);
    chk("ign_wait_req", 32'(imem_req), 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093;
    step();
    imem_rvalid = 1'b0;
    chk("ign_valid_pc", pc_o, RESET_PC);
    chk("ign_valid", 32'(inst_valid), 32'h1);

    // fetch counter wraps past all-ones
    do_reset();
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    step();
    release dut.fetch_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    chk("wrap_pre", fetch_cnt, 32'hFFFF_FFFF);
    fetch(0, 0, 32'h0000_0013);
    chk("wrap_zero", fetch_cnt, 32'h0);

    // randomized traffic against the PC/count model
    do_reset();
    for (int t = 0; t < 30; t++) begin
      logic [31:0] d;
      int          hold;
      d = $urandom;
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 1)), d);
      hold = int'($urandom_range(0, 2));
      for (int h = 0; h < hold; h++) begin
        imem_gnt = 1'($urandom_range(0, 1));
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        step();
        chk("hold_valid", 32'(inst_valid), 32'h1);
        chk("hold_inst", inst_o, d);
        chk("hold_pc", pc_o, exp_pc);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      retire($urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
